imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 13 +
 rtl/imem_loader.sv | 111 +++++++++++
 tb/tb_imem_loader.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - processor constants shared by the loader and processor top
package imem_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    localparam int HOLD_CYC_DEFAULT = 2;

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams a host program into instruction memory, then releases cpu reset
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 8,
    parameter int HOLD_CYC = HOLD_CYC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   word_count
);

    localparam int                CNT_W     = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
    localparam state_t            END_ST    = (HOLD_CYC > 0) ? ST_HOLD : ST_RUN;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [CNT_W-1:0]  hold_cnt;
    logic              accept;

    // in_ready is registered and high exactly while in LOAD; start wins over a word
    assign accept = in_valid && in_ready && !start;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            hold_cnt   <= '0;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            overflow   <= 1'b0;
            word_count <= '0;
        end else begin
            mem_we <= 1'b0;
            if (start) begin
                state      <= ST_LOAD;
                ptr        <= '0;
                hold_cnt   <= '0;
                in_ready   <= 1'b1;
                cpu_reset  <= 1'b1;
                done       <= 1'b0;
                overflow   <= 1'b0;
                word_count <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        in_ready <= 1'b0;
                    end
                    ST_LOAD: begin
                        if (accept) begin
                            mem_we     <= 1'b1;
                            mem_addr   <= ptr;
                            mem_wdata  <= in_data;
                            word_count <= word_count + 1'b1;
                            if (ptr != LAST_ADDR) begin
                                ptr <= ptr + 1'b1;
                            end
                            // the top address ends the load even without in_last; no wrap
                            if (in_last || ptr == LAST_ADDR) begin
                                state    <= END_ST;
                                in_ready <= 1'b0;
                                hold_cnt <= '0;
                                if (!in_last) begin
                                    overflow <= 1'b1;
                                end
                                if (HOLD_CYC == 0) begin
                                    cpu_reset <= 1'b0;
                                    done      <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (hold_cnt == HOLD_LAST) begin
                            state     <= ST_RUN;
                            cpu_reset <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    ST_RUN: begin
                        in_ready <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader
module tb_imem_loader;

    localparam int ADDR_W   = 3;
    localparam int DATA_W   = 8;
    localparam int HOLD_CYC = 2;
    localparam int DEPTH    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_reset;
    logic              done;
    logic              overflow;
    logic [ADDR_W:0]   word_count;

    imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOLD_CYC(HOLD_CYC)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset), .done(done), .overflow(overflow),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t got[$];
    wr_t exp[$];
    int  n_vec = 0;
    int  n_err = 0;
    bit  m_loading = 1'b0;
    int  m_count = 0;

    always @(negedge clk) begin
        if (mem_we === 1'b1) got.push_back({mem_addr, mem_wdata});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        m_loading = 1'b1;
        m_count = 0;
        exp.delete();
        got.delete();
    endtask

    // Present one word until the model says it is taken or max_wait cycles pass
    task automatic send_word(input logic [DATA_W-1:0] d, input bit last, input int max_wait,
                             output bit acc);
        acc = 1'b0;
        in_valid = 1'b1;
        in_data = d;
        in_last = last;
        for (int i = 0; i < max_wait && !acc; i++) begin
            n_vec++;
            if (in_ready !== m_loading) begin
                n_err++;
                $display("FAIL in_ready: got %b expected %b (word %0d)", in_ready, m_loading, m_count);
            end
            if (m_loading) begin
                acc = 1'b1;
                exp.push_back({ADDR_W'(m_count), d});
                m_count++;
                if (last || m_count == DEPTH) m_loading = 1'b0;
            end
            step();
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic gap(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b1;
        in_valid = 1'b1;
        step();
        reset = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        got.delete();
        n_vec++;
        if ({cpu_reset, in_ready, mem_we, done, overflow} !== 5'b10000) begin
            n_err++;
            $display("FAIL reset_flags: got cpu_reset/in_ready/mem_we/done/overflow=%b expected 10000",
                     {cpu_reset, in_ready, mem_we, done, overflow});
        end
        n_vec++;
        if (mem_addr !== '0 || mem_wdata !== '0 || word_count !== '0) begin
            n_err++;
            $display("FAIL reset_values: got addr=%0d wdata=%h count=%0d expected 0 0 0",
                     mem_addr, mem_wdata, word_count);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data = DATA_W'($urandom);
            step();
            n_vec++;
            if (cpu_reset !== 1'b1 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL idle: got cpu_reset=%b in_ready=%b expected 1 0", cpu_reset, in_ready);
            end
        end
        in_valid = 1'b0;
        step();
        n_vec++;
        if (got.size() != 0) begin
            n_err++;
            $display("FAIL idle_writes: got %0d writes expected 0", got.size());
        end
    endtask

    task automatic test_basic_load();
        logic [DATA_W-1:0] words [3];
        bit acc;
        words[0] = 8'h41; words[1] = 8'h12; words[2] = 8'hC3;
        pulse_start();
        n_vec++;
        if (in_ready !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0 || word_count !== '0) begin
            n_err++;
            $display("FAIL load_entry: got in_ready=%b cpu_reset=%b done=%b count=%0d expected 1 1 0 0",
                     in_ready, cpu_reset, done, word_count);
        end
        for (int i = 0; i < 3; i++) send_word(words[i], i == 2, 3, acc);
        for (int h = 0; h < HOLD_CYC; h++) begin
            n_vec++;
            if (cpu_reset !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
                n_err++;
                $display("FAIL basic_hold%0d: got cpu_reset=%b in_ready=%b done=%b expected 1 0 0",
                         h, cpu_reset, in_ready, done);
            end
            step();
        end
        n_vec++;
        if (cpu_reset !== 1'b0 || done !== 1'b1 || word_count !== 4'd3 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL basic_run: got cpu_reset=%b done=%b count=%0d ovf=%b expected 0 1 3 0",
                     cpu_reset, done, word_count, overflow);
        end
        n_vec++;
        if (got.size() != exp.size()) begin
            n_err++;
            $display("FAIL basic_nwrites: got %0d expected %0d", got.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            n_vec++;
            if (got[i] !== exp[i]) begin
                n_err++;
                $display("FAIL basic_write%0d: got addr=%0d data=%h expected addr=%0d data=%h",
                         i, got[i].addr, got[i].data, exp[i].addr, exp[i].data);
            end
        end
    endtask

    task automatic test_random_loads();
        bit acc;
        int n;
        for (int it = 0; it < 5; it++) begin
            n = $urandom_range(1, DEPTH);
            pulse_start();
            for (int i = 0; i < n; i++) begin
                gap((i % 2) + int'($urandom_range(0, 1)));
                send_word(DATA_W'($urandom), i == n - 1, 3, acc);
                n_vec++;
                if (word_count !== (ADDR_W + 1)'(m_count)) begin
                    n_err++;
                    $display("FAIL rand_count: got %0d expected %0d", word_count, m_count);
                end
            end
            for (int h = 0; h < HOLD_CYC; h++) begin
                n_vec++;
                if (cpu_reset !== 1'b1 || done !== 1'b0) begin
                    n_err++;
                    $display("FAIL rand_hold: got cpu_reset=%b done=%b expected 1 0", cpu_reset, done);
                end
                step();
            end
            n_vec++;
            if (cpu_reset !== 1'b0 || done !== 1'b1 || overflow !== 1'b0) begin
                n_err++;
                $display("FAIL rand_run: got cpu_reset=%b done=%b ovf=%b expected 0 1 0",
                         cpu_reset, done, overflow);
            end
            n_vec++;
            if (got.size() != exp.size()) begin
                n_err++;
                $display("FAIL rand_nwrites: got %0d expected %0d", got.size(), exp.size());
            end
            for (int i = 0; i < exp.size() && i < got.size(); i++) begin
                n_vec++;
                if (got[i] !== exp[i]) begin
                    n_err++;
                    $display("FAIL rand_write%0d: got addr=%0d data=%h expected addr=%0d data=%h",
                             i, got[i].addr, got[i].data, exp[i].addr, exp[i].data);
                end
            end
        end
    endtask

    task automatic test_overflow();
        bit acc;
        pulse_start();
        for (int i = 0; i < DEPTH; i++) send_word(DATA_W'($urandom), 1'b0, 3, acc);
        n_vec++;
        if (overflow !== 1'b1 || in_ready !== 1'b0 || word_count !== (ADDR_W + 1)'(DEPTH)) begin
            n_err++;
            $display("FAIL ovf_flag: got ovf=%b in_ready=%b count=%0d expected 1 0 %0d",
                     overflow, in_ready, word_count, DEPTH);
        end
        send_word(DATA_W'($urandom), 1'b0, 4, acc);
        n_vec++;
        if (done !== 1'b1 || cpu_reset !== 1'b0 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_run: got done=%b cpu_reset=%b ovf=%b expected 1 0 1",
                     done, cpu_reset, overflow);
        end
        n_vec++;
        if (got.size() != exp.size()) begin
            n_err++;
            $display("FAIL ovf_nwrites: got %0d expected %0d", got.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            n_vec++;
            if (got[i] !== exp[i]) begin
                n_err++;
                $display("FAIL ovf_write%0d: got addr=%0d data=%h expected addr=%0d data=%h",
                         i, got[i].addr, got[i].data, exp[i].addr, exp[i].data);
            end
        end
    endtask

    task automatic test_restart_run();
        bit acc;
        pulse_start();
        n_vec++;
        if ({cpu_reset, done, overflow, in_ready} !== 4'b1001 || word_count !== '0) begin
            n_err++;
            $display("FAIL restart: got cpu_reset/done/ovf/in_ready=%b count=%0d expected 1001 0",
                     {cpu_reset, done, overflow, in_ready}, word_count);
        end
        for (int i = 0; i < 3; i++) send_word(DATA_W'($urandom), i == 2, 3, acc);
        gap(HOLD_CYC);
        n_vec++;
        if (done !== 1'b1 || got.size() != 3) begin
            n_err++;
            $display("FAIL restart_load: got done=%b writes=%0d expected 1 3", done, got.size());
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            n_vec++;
            if (got[i] !== exp[i]) begin
                n_err++;
                $display("FAIL restart_write%0d: got addr=%0d data=%h expected addr=%0d data=%h",
                         i, got[i].addr, got[i].data, exp[i].addr, exp[i].data);
            end
        end
    endtask

    task automatic test_start_priority();
        bit acc;
        pulse_start();
        send_word(DATA_W'($urandom), 1'b0, 3, acc);
        gap(1);
        start = 1'b1;
        in_valid = 1'b1;
        in_data = DATA_W'($urandom);
        step();
        start = 1'b0;
        in_valid = 1'b0;
        m_loading = 1'b1;
        m_count = 0;
        exp.delete();
        got.delete();
        n_vec++;
        if (mem_we !== 1'b0 || word_count !== '0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL prio: got mem_we=%b count=%0d in_ready=%b expected 0 0 1",
                     mem_we, word_count, in_ready);
        end
        for (int i = 0; i < 2; i++) send_word(DATA_W'($urandom), i == 1, 3, acc);
        gap(1);
        n_vec++;
        if (got.size() != exp.size()) begin
            n_err++;
            $display("FAIL prio_nwrites: got %0d expected %0d", got.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            n_vec++;
            if (got[i] !== exp[i]) begin
                n_err++;
                $display("FAIL prio_write%0d: got addr=%0d data=%h expected addr=%0d data=%h",
                         i, got[i].addr, got[i].data, exp[i].addr, exp[i].data);
            end
        end
        gap(HOLD_CYC);
    endtask

    task automatic test_reset_mid_load();
        bit acc;
        pulse_start();
        for (int i = 0; i < 2; i++) send_word(DATA_W'($urandom), 1'b0, 3, acc);
        gap(1);
        n_vec++;
        if (got.size() != 2 || word_count !== 4'd2) begin
            n_err++;
            $display("FAIL mid_pre: got writes=%0d count=%0d expected 2 2", got.size(), word_count);
        end
        reset = 1'b0;
        in_valid = 1'b1;
        in_data = DATA_W'($urandom);
        step();
        reset = 1'b1;
        got.delete();
        n_vec++;
        if (in_ready !== 1'b0 || cpu_reset !== 1'b1 || word_count !== '0 || mem_we !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: got in_ready=%b cpu_reset=%b count=%0d mem_we=%b expected 0 1 0 0",
                     in_ready, cpu_reset, word_count, mem_we);
        end
        for (int i = 0; i < 4; i++) begin
            in_data = DATA_W'($urandom);
            step();
        end
        in_valid = 1'b0;
        step();
        n_vec++;
        if (got.size() != 0 || in_ready !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL mid_idle: got writes=%0d in_ready=%b done=%b expected 0 0 0",
                     got.size(), in_ready, done);
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_random_loads();
        test_overflow();
        test_restart_run();
        test_start_priority();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
